// File: rtl/sevga_pkg.sv
// Shared raster/slot constants and scanout state encoding for the VGA framebuffer path.
package sevga_pkg;

  localparam int unsigned VGA_W     = 640;
  localparam int unsigned VGA_H     = 480;
  localparam int unsigned MAC_W     = 512;
  localparam int unsigned MAC_H     = 342;
  localparam int unsigned MAC_BYTES = 21888;

  localparam int unsigned HC_W   = 10;
  localparam int unsigned VC_W   = 10;
  localparam int unsigned ADDR_W = 15;
  localparam int unsigned SEQ_W  = 3;
  localparam int unsigned BYTE_W = 8;

  localparam logic [SEQ_W-1:0] SEQ_RD_ADDR = 3'd6;
  localparam logic [SEQ_W-1:0] SEQ_RD_DATA = 3'd7;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    IDLE      = 2'd1,
    ADDR      = 2'd2,
    DATA      = 2'd3
  } scan_state_t;

  // 68000 big-endian: the leftmost pixels live in the high byte at the odd address.
  function automatic logic [ADDR_W-1:0] byte_addr(input logic [ADDR_W-1:0] ptr);
    return {ptr[ADDR_W-1:1], ~ptr[0]};
  endfunction

endpackage

// File: rtl/pix_shifter.sv
// 8-bit pixel serializer: loads a fetched byte (or border zeros) once per group, then shifts MSB-first.
module pix_shifter
  import sevga_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [BYTE_W-1:0] data,
  output logic              msb
);

  logic [BYTE_W-1:0] sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh <= '0;
    end else if (load) begin
      sh <= data;
    end else begin
      sh <= {sh[BYTE_W-2:0], 1'b0};
    end
  end

  assign msb = sh[BYTE_W-1];

endmodule

// File: rtl/vram_scanout.sv
// Video-side VRAM reader: one byte fetch per 8-pixel group in seq 6-7, serialized to 1 bpp.
// Optional build macro SCANOUT_INVERT_EN inverts pixels inside the image window only.
module vram_scanout
  import sevga_pkg::*;
#(
  parameter int unsigned H_OFFSET = 64,
  parameter int unsigned V_OFFSET = 69,
  parameter int unsigned H_PIXELS = MAC_W,
  parameter int unsigned V_LINES  = MAC_H
) (
  input  logic              pixClock,
  input  logic              Reset,
  input  logic [HC_W-1:0]   hCount,
  input  logic [VC_W-1:0]   vCount,
  input  logic [BYTE_W-1:0] vramDataIn,
  output logic [ADDR_W-1:0] vramAddr,
  output logic              nvramOE,
  output logic              rdSlot,
  output logic              pixOut,
  output logic              frameDone
);

  localparam int unsigned GW        = HC_W + 1;
  localparam int unsigned LAST_BYTE = (H_PIXELS / 8) * V_LINES - 1;

  localparam logic [GW-1:0]     H_LO = GW'(H_OFFSET);
  localparam logic [GW-1:0]     H_HI = GW'(H_OFFSET + H_PIXELS);
  localparam logic [VC_W-1:0]   V_LO = VC_W'(V_OFFSET);
  localparam logic [VC_W-1:0]   V_HI = VC_W'(V_OFFSET + V_LINES);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(LAST_BYTE);
  localparam logic [SEQ_W-1:0]  SEQ_DECIDE = SEQ_RD_ADDR - 3'd1;

  scan_state_t       state, state_d;
  logic [ADDR_W-1:0] fetch_ptr, ptr_d;
  logic [ADDR_W-1:0] addr_d;
  logic              slot_d;
  logic              done_d;

  logic [SEQ_W-1:0]  seq;
  logic [GW-1:0]     g_next;
  logic              fetch_ok;
  logic              fetched;
  logic [BYTE_W-1:0] load_data;

  assign seq = hCount[SEQ_W-1:0];

  // Decided one clock early (seq 5) so the bus outputs are registered exactly over seq 6 and 7.
  assign g_next   = GW'(hCount) + GW'(3);
  assign fetch_ok = (seq == SEQ_DECIDE)
                 && (g_next >= H_LO) && (g_next < H_HI)
                 && (vCount >= V_LO) && (vCount < V_HI);

  always_ff @(posedge pixClock or posedge Reset) begin
    if (Reset) begin
      state     <= WAIT_SYNC;
      fetch_ptr <= '0;
      vramAddr  <= '0;
      rdSlot    <= 1'b0;
      nvramOE   <= 1'b1;
      frameDone <= 1'b0;
    end else begin
      state     <= state_d;
      fetch_ptr <= ptr_d;
      vramAddr  <= addr_d;
      rdSlot    <= slot_d;
      nvramOE   <= ~slot_d;
      frameDone <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    ptr_d   = fetch_ptr;
    addr_d  = vramAddr;
    slot_d  = 1'b0;
    done_d  = 1'b0;
    case (state)
      WAIT_SYNC: begin
        // Stay dark until the frame top so a mid-frame reset never shows a shifted image.
        ptr_d = '0;
        if (vCount < V_LO) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (vCount < V_LO) begin
          ptr_d = '0;
        end
        if (fetch_ok) begin
          state_d = ADDR;
          slot_d  = 1'b1;
          addr_d  = byte_addr(fetch_ptr);
        end
      end
      ADDR: begin
        state_d = DATA;
        slot_d  = 1'b1;
      end
      DATA: begin
        state_d = IDLE;
        if (fetch_ptr == PTR_LAST) begin
          ptr_d  = '0;
          done_d = 1'b1;
        end else begin
          ptr_d = fetch_ptr + ADDR_W'(1);
        end
      end
      default: begin
        state_d = WAIT_SYNC;
      end
    endcase
  end

  assign fetched = (state == DATA);

  // Inverting at load time keeps border groups (loaded with zeros) unaffected.
`ifdef SCANOUT_INVERT_EN
  assign load_data = fetched ? ~vramDataIn : '0;
`else
  assign load_data = fetched ? vramDataIn : '0;
`endif

  pix_shifter u_shifter (
    .clk  (pixClock),
    .rst  (Reset),
    .load (seq == SEQ_RD_DATA),
    .data (load_data),
    .msb  (pixOut)
  );

endmodule

// File: tb/tb_vram_scanout.sv
// Self-checking bench for vram_scanout: directed vector table plus a raster-level reference model over random VRAM.
module tb_vram_scanout;

  localparam int H_OFF = 64;
  localparam int V_OFF = 69;
  localparam int H_PIX = 512;
  localparam int V_LIN = 342;
  localparam int BPL   = H_PIX / 8;
`ifdef SCANOUT_INVERT_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic        pixClock = 1'b0;
  logic        Reset = 1'b1;
  logic [9:0]  hCount = 10'd0;
  logic [9:0]  vCount = 10'd200;
  logic [7:0]  vramDataIn = 8'h00;
  logic [14:0] vramAddr;
  logic        nvramOE;
  logic        rdSlot;
  logic        pixOut;
  logic        frameDone;

  always #5 pixClock = ~pixClock;

  vram_scanout dut (
    .pixClock   (pixClock),
    .Reset      (Reset),
    .hCount     (hCount),
    .vCount     (vCount),
    .vramDataIn (vramDataIn),
    .vramAddr   (vramAddr),
    .nvramOE    (nvramOE),
    .rdSlot     (rdSlot),
    .pixOut     (pixOut),
    .frameDone  (frameDone)
  );

  typedef struct {
    int          v;
    int          h;
    bit          rd;
    logic [14:0] addr;
    bit          chk_pix;
    bit          pix;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] vram [32768];
  int         checks = 0;
  int         errors = 0;
  bit         armed = 1'b0;
  int         prev_v = -1;
  int         prev_h = -1;
  int         fetches = 0;
  int         dones = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at v=%0d h=%0d: actual=%0h expected=%0h", name, vCount, hCount, act, exp);
    end
  endtask

  task automatic reset_chk();
    chk("rst_vramAddr", 32'(vramAddr), 32'd0);
    chk("rst_nvramOE", 32'(nvramOE), 32'd1);
    chk("rst_rdSlot", 32'(rdSlot), 32'd0);
    chk("rst_pixOut", 32'(pixOut), 32'd0);
    chk("rst_frameDone", 32'(frameDone), 32'd0);
  endtask

  // One pixel clock: drive raster position, serve VRAM, compare against the raster model.
  task automatic step(input int h, input int v, input bit chk_pix);
    int  seq, g, idx;
    bit  vwin, exp_rd, exp_done, exp_pix;
    logic [7:0] b;
    @(posedge pixClock);
    #1;
    hCount = 10'(h);
    vCount = 10'(v);
    vramDataIn = vram[vramAddr];
    #3;
    seq  = h % 8;
    g    = h - seq + 8;
    vwin = (v >= V_OFF) && (v < V_OFF + V_LIN);
    exp_rd = armed && vwin && (seq >= 6) && (g >= H_OFF) && (g < H_OFF + H_PIX);
    chk("rdSlot", 32'(rdSlot), 32'(exp_rd));
    chk("nvramOE", 32'(nvramOE), 32'(!exp_rd));
    if (exp_rd) begin
      idx = (v - V_OFF) * BPL + (g - H_OFF) / 8;
      chk("vramAddr", 32'(vramAddr), 32'(idx ^ 1));
      if (seq == 6) fetches++;
    end
    exp_done = armed && (prev_v == V_OFF + V_LIN - 1) && (prev_h == H_OFF + H_PIX - 9);
    chk("frameDone", 32'(frameDone), 32'(exp_done));
    if (frameDone === 1'b1) dones++;
    if (chk_pix) begin
      exp_pix = 1'b0;
      if (armed && vwin && (h >= H_OFF) && (h < H_OFF + H_PIX)) begin
        idx = (v - V_OFF) * BPL + (h - H_OFF) / 8;
        b = vram[idx ^ 1];
        exp_pix = b[7 - (h % 8)] ^ INV;
      end
      chk("pixOut", 32'(pixOut), 32'(exp_pix));
    end
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].v == v && vecs[i].h == h) begin
        chk("tbl_rdSlot", 32'(rdSlot), 32'(vecs[i].rd));
        if (vecs[i].rd) chk("tbl_vramAddr", 32'(vramAddr), 32'(vecs[i].addr));
        if (vecs[i].chk_pix) chk("tbl_pixOut", 32'(pixOut), 32'(vecs[i].pix));
      end
    end
    prev_v = v;
    prev_h = h;
    if (v < V_OFF) armed = 1'b1;
  endtask

  task automatic line_full(input int v);
    for (int h = 0; h < 800; h++) step(h, v, h >= 8);
  endtask

  // Only seq 5..7 of each group: enough to run the fetch engine, not the pixel stream.
  task automatic line_fast(input int v);
    for (int k = 7; k <= 71; k++) begin
      step(k * 8 + 5, v, 1'b0);
      step(k * 8 + 6, v, 1'b0);
      step(k * 8 + 7, v, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] pat;
    for (int i = 0; i < 32768; i++) vram[i] = 8'($urandom);
    vram[1] = 8'hA5;
    pat = 8'hA5;

    vecs.push_back('{v: 69,  h: 61,  rd: 1'b0, addr: 15'h0000, chk_pix: 1'b0, pix: 1'b0});
    vecs.push_back('{v: 69,  h: 62,  rd: 1'b1, addr: 15'h0001, chk_pix: 1'b0, pix: 1'b0});
    vecs.push_back('{v: 69,  h: 63,  rd: 1'b1, addr: 15'h0001, chk_pix: 1'b1, pix: 1'b0});
    vecs.push_back('{v: 69,  h: 70,  rd: 1'b1, addr: 15'h0000, chk_pix: 1'b0, pix: 1'b0});
    vecs.push_back('{v: 70,  h: 62,  rd: 1'b1, addr: 15'h0041, chk_pix: 1'b0, pix: 1'b0});
    vecs.push_back('{v: 410, h: 566, rd: 1'b1, addr: 15'h557E, chk_pix: 1'b0, pix: 1'b0});
    vecs.push_back('{v: 410, h: 574, rd: 1'b0, addr: 15'h0000, chk_pix: 1'b0, pix: 1'b0});
    vecs.push_back('{v: 411, h: 62,  rd: 1'b0, addr: 15'h0000, chk_pix: 1'b0, pix: 1'b0});
    vecs.push_back('{v: 69,  h: 576, rd: 1'b0, addr: 15'h0000, chk_pix: 1'b1, pix: 1'b0});
    vecs.push_back('{v: 69,  h: 639, rd: 1'b0, addr: 15'h0000, chk_pix: 1'b1, pix: 1'b0});
    vecs.push_back('{v: 70,  h: 0,   rd: 1'b0, addr: 15'h0000, chk_pix: 1'b1, pix: 1'b0});
    for (int i = 0; i < 8; i++)
      vecs.push_back('{v: 69, h: 64 + i, rd: (i >= 6), addr: 15'h0000 ^ 15'(i >= 6 ? 0 : 0),
                       chk_pix: 1'b1, pix: pat[7 - i] ^ INV});

    // Power-up reset at mid-frame line 200.
    repeat (3) @(posedge pixClock);
    #1;
    reset_chk();
    @(posedge pixClock);
    #2;
    Reset = 1'b0;

    line_full(200);
    line_fast(300);
    line_fast(68);
    line_full(69);
    line_full(70);
    for (int v = 71; v < 410; v++) line_fast(v);
    line_full(410);
    line_full(411);
    line_fast(420);
    chk("fetch_count", 32'(fetches), 32'd21888);
    chk("frameDone_count", 32'(dones), 32'd1);

    // Reset in the middle of an image, then confirm nothing is shown before the next frame top.
    line_fast(68);
    line_fast(69);
    @(posedge pixClock);
    #2;
    Reset = 1'b1;
    armed = 1'b0;
    #1;
    reset_chk();
    @(posedge pixClock);
    #2;
    Reset = 1'b0;
    line_full(100);
    line_fast(150);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
